instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory interface: owns the program counter, drives the byte address to the instruction memory, and captures the returned 32-bit instruction into the IF/ID pipeline register. It supports hazard stalls, branch/jump redirects with flush, misaligned-target trapping, and an end-of-program halt. It sits between the instruction memory and the decode stage of the pipelined core.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset
TRAP_PC, 64'd64, PC loaded when a misaligned redirect target is seen
MEM_BYTES, 88, instruction memory size in bytes; fetch halts at PC >= MEM_BYTES
NOP_INSN, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/halt

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  hazard unit request to hold PC and IF/ID
Redirect  input  1  branch/jump taken, resolved downstream
Redirect_PC  input  64  target byte address for Redirect
Inst_Address  output  64  byte address to instruction memory (= PC, combinational)
Instruction  input  32  instruction word returned combinationally by memory
IFID_PC  output  64  PC of instruction held in IF/ID
IFID_Instruction  output  32  instruction held in IF/ID
IFID_Valid  output  1  IF/ID holds a real instruction
Misaligned_Trap  output  1  one-cycle pulse: redirect target misaligned
Halted  output  1  PC has run past MEM_BYTES; fetch stopped

Behaviour:
- Reset (sync, active-high) dominates all: PC=RESET_PC, IFID_PC=0, IFID_Instruction=NOP_INSN, IFID_Valid=0, Misaligned_Trap=0, Halted=0. Reset asserted mid-stall or mid-redirect discards both.
- Inst_Address = PC at all times; memory read is zero-latency, so Instruction is valid in the same cycle.
- Priority each edge: reset > Redirect > Halted > Stall > normal advance.
- Normal (no stall, no redirect, not halted): IFID_PC<=PC, IFID_Instruction<=Instruction, IFID_Valid<=1, PC<=PC+4 (64-bit modular add, wraps at 2^64).
- Stall=1 (no redirect): PC, IFID_PC, IFID_Instruction and IFID_Valid all hold.
- Redirect=1 (overrides Stall and Halted): IF/ID flushed (IFID_Instruction<=NOP_INSN, IFID_Valid<=0, IFID_PC<=0); Halted<=0.
  - Redirect_PC[1:0]==0: PC<=Redirect_PC, Misaligned_Trap<=0.
  - Redirect_PC[1:0]!=0: PC<=TRAP_PC, Misaligned_Trap<=1 for exactly one cycle.
- Misaligned_Trap is 0 in every cycle not immediately following a misaligned redirect.
- Halt: in a cycle with no redirect and PC >= MEM_BYTES (unsigned compare), Halted<=1, IF/ID loads bubble (NOP_INSN, Valid=0). Once Halted=1, PC holds and IF/ID stays bubble regardless of Stall, until Redirect or reset. The instruction at PC=MEM_BYTES-4 is captured normally; halt takes effect the following cycle.
- Redirect in the same cycle as a halt condition: redirect wins; no halt.
- PC[1:0] is always 00 after reset (only +4, aligned redirects, aligned TRAP_PC).

Test Plan:
- Reset then 4 free-running cycles with the four-instruction program loaded -> Inst_Address 0,4,8,12; IFID_Instruction 0x00043483, 0x008484B3, 0x009A84B3, 0x00148493 with IFID_PC 0,4,8,12, IFID_Valid=1.
- Stall=1 for 2 cycles at PC=8 -> Inst_Address stays 8, IFID holds PC=4/0x008484B3; release -> IFID PC=8/0x009A84B3 next edge.
- Redirect=1, Redirect_PC=0 while Stall=1 at PC=12 -> next cycle PC=0, IFID_Valid=0, IFID_Instruction=0x00000013; following cycle IFID PC=0/0x00043483.
- Redirect_PC=0x6 -> next cycle PC=64, Misaligned_Trap=1 for one cycle only, IFID_Valid=0.
- Free-run to PC=84 -> IFID_PC=84 captured, then Halted=1, PC holds 88, IFID_Valid=0; Redirect_PC=0 clears Halted, fetch resumes at 0.
- Assert reset during a stalled, halted state -> all outputs return to reset values next edge, PC=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Handles stalls, redirect with flush, misaligned-target trap and end-of-memory halt.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [63:0] TRAP_PC   = 64'd64,
  parameter int unsigned MEM_BYTES = 88,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [63:0] Redirect_PC,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
  output logic        Misaligned_Trap,
  output logic        Halted
);

  localparam logic [63:0] PC_STEP  = 64'd4;
  localparam logic [63:0] PC_LIMIT = 64'(MEM_BYTES);

  logic [63:0] pc;
  logic        halt_cond;
  logic        misaligned;

  assign Inst_Address = pc;

  // Once halted, stay halted until a redirect; otherwise halt as soon as PC leaves memory.
  always_comb begin
    halt_cond  = Halted || (pc >= PC_LIMIT);
    misaligned = |Redirect_PC[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_PC;
      IFID_PC          <= 64'd0;
      IFID_Instruction <= NOP_INSN;
      IFID_Valid       <= 1'b0;
      Misaligned_Trap  <= 1'b0;
      Halted           <= 1'b0;
    end else if (Redirect) begin
      IFID_PC          <= 64'd0;
      IFID_Instruction <= NOP_INSN;
      IFID_Valid       <= 1'b0;
      Halted           <= 1'b0;
      Misaligned_Trap  <= misaligned;
      pc               <= misaligned ? TRAP_PC : Redirect_PC;
    end else if (halt_cond) begin
      IFID_PC          <= 64'd0;
      IFID_Instruction <= NOP_INSN;
      IFID_Valid       <= 1'b0;
      Misaligned_Trap  <= 1'b0;
      Halted           <= 1'b1;
    end else if (Stall) begin
      Misaligned_Trap  <= 1'b0;
    end else begin
      IFID_PC          <= pc;
      IFID_Instruction <= Instruction;
      IFID_Valid       <= 1'b1;
      Misaligned_Trap  <= 1'b0;
      pc               <= pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural model feeds a scoreboard of expected
// post-edge outputs, plus directed scenario checks with fixed expected values.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] ifid_pc;
    logic [31:0] insn;
    logic        valid;
    logic        pc_known;
    logic        trap;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [63:0] Redirect_PC = 64'd0;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid;
  logic        Misaligned_Trap;
  logic        Halted;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  logic [31:0] mem [0:21];
  logic [63:0] m_pc, m_ifid_pc;
  logic [31:0] m_insn;
  logic        m_valid, m_trap, m_halted;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .IFID_PC(IFID_PC), .IFID_Instruction(IFID_Instruction), .IFID_Valid(IFID_Valid),
    .Misaligned_Trap(Misaligned_Trap), .Halted(Halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fetch(input logic [63:0] a);
    if (a < 64'd88) return mem[a[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign Instruction = fetch(Inst_Address);

  // Drive one cycle of inputs, predict the post-edge state and queue it.
  task automatic step(input logic rst, input logic st, input logic rd, input logic [63:0] rpc);
    exp_t e;
    @(negedge clk);
    reset = rst; Stall = st; Redirect = rd; Redirect_PC = rpc;
    e.pc_known = 1'b1;
    if (rst) begin
      e.addr = 64'd0; e.ifid_pc = 64'd0; e.insn = NOP; e.valid = 1'b0;
      e.trap = 1'b0; e.halted = 1'b0;
    end else if (rd) begin
      e.ifid_pc = 64'd0; e.insn = NOP; e.valid = 1'b0; e.halted = 1'b0;
      e.trap = (rpc[1:0] != 2'b00);
      e.addr = e.trap ? 64'd64 : rpc;
    end else if (m_halted || m_pc >= 64'd88) begin
      e.addr = m_pc; e.ifid_pc = 64'd0; e.insn = NOP; e.valid = 1'b0;
      e.pc_known = 1'b0; e.trap = 1'b0; e.halted = 1'b1;
    end else if (st) begin
      e.addr = m_pc; e.ifid_pc = m_ifid_pc; e.insn = m_insn; e.valid = m_valid;
      e.trap = 1'b0; e.halted = 1'b0;
    end else begin
      e.addr = m_pc + 64'd4; e.ifid_pc = m_pc; e.insn = fetch(m_pc); e.valid = 1'b1;
      e.trap = 1'b0; e.halted = 1'b0;
    end
    m_pc = e.addr; m_ifid_pc = e.ifid_pc; m_insn = e.insn; m_valid = e.valid;
    m_trap = e.trap; m_halted = e.halted;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare each queued prediction just after the edge it belongs to.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (Inst_Address !== e.addr) begin
        miscompares++;
        $display("FAIL sb_addr got %h want %h at %0t", Inst_Address, e.addr, $time);
      end
      vectors++;
      if (IFID_Valid !== e.valid || IFID_Instruction !== e.insn) begin
        miscompares++;
        $display("FAIL sb_ifid got v=%b %h want v=%b %h at %0t",
                 IFID_Valid, IFID_Instruction, e.valid, e.insn, $time);
      end
      if (e.pc_known) begin
        vectors++;
        if (IFID_PC !== e.ifid_pc) begin
          miscompares++;
          $display("FAIL sb_ifid_pc got %h want %h at %0t", IFID_PC, e.ifid_pc, $time);
        end
      end
      vectors++;
      if (Misaligned_Trap !== e.trap || Halted !== e.halted) begin
        miscompares++;
        $display("FAIL sb_flags got trap=%b halt=%b want trap=%b halt=%b at %0t",
                 Misaligned_Trap, Halted, e.trap, e.halted, $time);
      end
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 64'd0);
    vectors++;
    if (Inst_Address !== 64'd0 || IFID_Valid !== 1'b0 || IFID_Instruction !== NOP ||
        IFID_PC !== 64'd0 || Halted !== 1'b0 || Misaligned_Trap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got pc=%h v=%b i=%h ipc=%h h=%b t=%b want 0,0,%h,0,0,0",
               Inst_Address, IFID_Valid, IFID_Instruction, IFID_PC, Halted, Misaligned_Trap, NOP);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] prog [0:3];
    prog[0] = 32'h0004_3483; prog[1] = 32'h0084_84B3;
    prog[2] = 32'h009A_84B3; prog[3] = 32'h0014_8493;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (Inst_Address !== 64'(4 * k)) begin
        miscompares++;
        $display("FAIL seq_addr%0d got %h want %h", k, Inst_Address, 64'(4 * k));
      end
      step(1'b0, 1'b0, 1'b0, 64'd0);
      vectors++;
      if (IFID_PC !== 64'(4 * k) || IFID_Instruction !== prog[k] || IFID_Valid !== 1'b1) begin
        miscompares++;
        $display("FAIL seq_ifid%0d got %h/%h/%b want %h/%h/1",
                 k, IFID_PC, IFID_Instruction, IFID_Valid, 64'(4 * k), prog[k]);
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0);
      vectors++;
      if (Inst_Address !== 64'd8 || IFID_PC !== 64'd4 || IFID_Instruction !== 32'h0084_84B3) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %h %h/%h want 8 4/008484b3",
                 k, Inst_Address, IFID_PC, IFID_Instruction);
      end
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    vectors++;
    if (IFID_PC !== 64'd8 || IFID_Instruction !== 32'h009A_84B3 || Inst_Address !== 64'd12) begin
      miscompares++;
      $display("FAIL stall_release got %h/%h pc=%h want 8/009a84b3 pc=c",
               IFID_PC, IFID_Instruction, Inst_Address);
    end
  endtask

  task automatic test_redirect();
    step(1'b0, 1'b1, 1'b1, 64'd0);
    vectors++;
    if (Inst_Address !== 64'd0 || IFID_Valid !== 1'b0 || IFID_Instruction !== NOP) begin
      miscompares++;
      $display("FAIL redirect_flush got pc=%h v=%b i=%h want 0/0/%h",
               Inst_Address, IFID_Valid, IFID_Instruction, NOP);
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    vectors++;
    if (IFID_PC !== 64'd0 || IFID_Instruction !== 32'h0004_3483 || IFID_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL redirect_resume got %h/%h/%b want 0/00043483/1",
               IFID_PC, IFID_Instruction, IFID_Valid);
    end
  endtask

  task automatic test_misaligned();
    step(1'b0, 1'b0, 1'b1, 64'h6);
    vectors++;
    if (Inst_Address !== 64'd64 || Misaligned_Trap !== 1'b1 || IFID_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_set got pc=%h t=%b v=%b want 40/1/0",
               Inst_Address, Misaligned_Trap, IFID_Valid);
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    vectors++;
    if (Misaligned_Trap !== 1'b0 || IFID_PC !== 64'd64) begin
      miscompares++;
      $display("FAIL trap_pulse got t=%b ipc=%h want 0/40", Misaligned_Trap, IFID_PC);
    end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 12 && m_pc < 64'd88; k++) step(1'b0, 1'b0, 1'b0, 64'd0);
    vectors++;
    if (IFID_PC !== 64'd84 || IFID_Valid !== 1'b1 || Inst_Address !== 64'd88 || Halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_last got ipc=%h v=%b pc=%h h=%b want 54/1/58/0",
               IFID_PC, IFID_Valid, Inst_Address, Halted);
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    vectors++;
    if (Halted !== 1'b1 || Inst_Address !== 64'd88 || IFID_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_hold got h=%b pc=%h v=%b want 1/58/0", Halted, Inst_Address, IFID_Valid);
    end
    step(1'b0, 1'b0, 1'b1, 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    vectors++;
    if (Halted !== 1'b0 || IFID_PC !== 64'd0 || IFID_Instruction !== 32'h0004_3483) begin
      miscompares++;
      $display("FAIL halt_resume got h=%b %h/%h want 0 0/00043483", Halted, IFID_PC, IFID_Instruction);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 64'd84);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    step(1'b1, 1'b1, 1'b0, 64'd0);
    vectors++;
    if (Inst_Address !== 64'd0 || Halted !== 1'b0 || IFID_Valid !== 1'b0 || IFID_Instruction !== NOP) begin
      miscompares++;
      $display("FAIL reset_mid got pc=%h h=%b v=%b i=%h want 0/0/0/%h",
               Inst_Address, Halted, IFID_Valid, IFID_Instruction, NOP);
    end
    step(1'b1, 1'b0, 1'b1, 64'h5);
    vectors++;
    if (Inst_Address !== 64'd0 || Misaligned_Trap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_over_redirect got pc=%h t=%b want 0/0", Inst_Address, Misaligned_Trap);
    end
  endtask

  task automatic test_random();
    logic [63:0] targets [0:8];
    targets[0] = 64'd0;  targets[1] = 64'd4;  targets[2] = 64'd8;
    targets[3] = 64'd80; targets[4] = 64'd88; targets[5] = 64'd6;
    targets[6] = 64'd1;  targets[7] = 64'd64; targets[8] = 64'd100;
    for (int k = 0; k < 80; k++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), targets[$urandom_range(0, 8)]);
    end
  endtask

  initial begin
    mem[0] = 32'h0004_3483; mem[1] = 32'h0084_84B3;
    mem[2] = 32'h009A_84B3; mem[3] = 32'h0014_8493;
    for (int i = 4; i < 22; i++) mem[i] = {16'hA5A5, 16'(i)};
    m_pc = 64'd0; m_ifid_pc = 64'd0; m_insn = NOP;
    m_valid = 1'b0; m_trap = 1'b0; m_halted = 1'b0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_reset_mid();
    test_random();

    #10;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
